// File: rtl/vadd_ctrl_seq.sv
// Host-side job sequencer for an HLS vadd kernel: programs the AXI4-Lite control
// registers, pulses ap_start, polls ap_done and reports completion with an error flag.
module vadd_ctrl_seq #(
    parameter int ADDR_WIDTH = 6,
    parameter int POLL_GAP   = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [63:0]           cmd_a_ptr,
    input  logic [63:0]           cmd_b_ptr,
    input  logic [63:0]           cmd_c_ptr,
    input  logic [31:0]           cmd_len,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  done_err,
    output logic                  m_axi_control_AWVALID,
    input  logic                  m_axi_control_AWREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_control_AWADDR,
    output logic                  m_axi_control_WVALID,
    input  logic                  m_axi_control_WREADY,
    output logic [31:0]           m_axi_control_WDATA,
    output logic [3:0]            m_axi_control_WSTRB,
    input  logic                  m_axi_control_BVALID,
    output logic                  m_axi_control_BREADY,
    input  logic [1:0]            m_axi_control_BRESP,
    output logic                  m_axi_control_ARVALID,
    input  logic                  m_axi_control_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_control_ARADDR,
    input  logic                  m_axi_control_RVALID,
    output logic                  m_axi_control_RREADY,
    input  logic [31:0]           m_axi_control_RDATA,
    input  logic [1:0]            m_axi_control_RRESP
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, GAP, DONE} state_t;

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    // Register programming order; index 7 is the ap_start write.
    function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [2:0] idx);
        logic [7:0] a8;
        case (idx)
            3'd0:    a8 = 8'h10;
            3'd1:    a8 = 8'h14;
            3'd2:    a8 = 8'h1C;
            3'd3:    a8 = 8'h20;
            3'd4:    a8 = 8'h28;
            3'd5:    a8 = 8'h2C;
            3'd6:    a8 = 8'h34;
            default: a8 = 8'h00;
        endcase
        return ADDR_WIDTH'(a8);
    endfunction

    function automatic logic [31:0] wr_data(input logic [2:0] idx, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] c,
                                            input logic [31:0] len);
        case (idx)
            3'd0:    return a[31:0];
            3'd1:    return a[63:32];
            3'd2:    return b[31:0];
            3'd3:    return b[63:32];
            3'd4:    return c[31:0];
            3'd5:    return c[63:32];
            3'd6:    return len;
            default: return 32'h1;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [63:0]             a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0]             len_q, len_d;
    logic [2:0]              wr_idx_q, wr_idx_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [2:0]              nxt_idx;
    logic                    unused_rdata;

    assign nxt_idx      = wr_idx_q + 3'd1;
    assign unused_rdata = ^{m_axi_control_RDATA[31:2], m_axi_control_RDATA[0]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q <= '0; b_q <= '0; c_q <= '0; len_q <= '0;
            wr_idx_q  <= '0;
            awvalid_q <= 1'b0; wvalid_q <= 1'b0; arvalid_q <= 1'b0;
            awaddr_q  <= '0; wdata_q <= '0;
            err_q     <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            a_q <= a_d; b_q <= b_d; c_q <= c_d; len_q <= len_d;
            wr_idx_q  <= wr_idx_d;
            awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d; wdata_q <= wdata_d;
            err_q     <= err_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d = a_q; b_d = b_q; c_d = c_q; len_d = len_q;
        wr_idx_d  = wr_idx_q;
        awvalid_d = awvalid_q; wvalid_d = wvalid_q; arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q; wdata_d = wdata_q;
        err_d     = err_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                a_d = cmd_a_ptr; b_d = cmd_b_ptr; c_d = cmd_c_ptr; len_d = cmd_len;
                err_d     = 1'b0;
                wr_idx_d  = 3'd0;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = wr_addr(3'd0);
                wdata_d   = wr_data(3'd0, cmd_a_ptr, cmd_b_ptr, cmd_c_ptr, cmd_len);
                state_d   = WR_REQ;
            end
            WR_REQ: begin
                // AW and W channels retire independently; wait for whichever is slower.
                if (m_axi_control_AWREADY) awvalid_d = 1'b0;
                if (m_axi_control_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_control_AWREADY) && (!wvalid_q || m_axi_control_WREADY))
                    state_d = WR_RESP;
            end
            WR_RESP: if (m_axi_control_BVALID) begin
                if (m_axi_control_BRESP != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (wr_idx_q == 3'd7) begin
                    arvalid_d = 1'b1;
                    state_d   = RD_REQ;
                end else begin
                    wr_idx_d  = nxt_idx;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = wr_addr(nxt_idx);
                    wdata_d   = wr_data(nxt_idx, a_q, b_q, c_q, len_q);
                    state_d   = WR_REQ;
                end
            end
            RD_REQ: if (m_axi_control_ARREADY) begin
                arvalid_d = 1'b0;
                state_d   = RD_RESP;
            end
            RD_RESP: if (m_axi_control_RVALID) begin
                if (m_axi_control_RRESP != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (m_axi_control_RDATA[1]) begin
                    state_d = DONE;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    arvalid_d = 1'b1;
                    state_d   = RD_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready             = (state_q == IDLE);
        done_valid            = (state_q == DONE);
        done_err              = (state_q == DONE) && err_q;
        m_axi_control_AWVALID = awvalid_q;
        m_axi_control_AWADDR  = awaddr_q;
        m_axi_control_WVALID  = wvalid_q;
        m_axi_control_WDATA   = wdata_q;
        m_axi_control_WSTRB   = 4'hF;
        m_axi_control_BREADY  = (state_q == WR_RESP);
        m_axi_control_ARVALID = arvalid_q;
        m_axi_control_ARADDR  = '0;
        m_axi_control_RREADY  = (state_q == RD_RESP);
    end

endmodule

// File: tb/tb_vadd_ctrl_seq.sv
// Scoreboard bench for vadd_ctrl_seq: a behavioural AXI4-Lite slave answers the
// sequencer, expected writes/completions are queued at job issue and checked by a monitor.
module tb_vadd_ctrl_seq;
    localparam int AW = 6;
    localparam int PG = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [63:0]   cmd_a_ptr = '0, cmd_b_ptr = '0, cmd_c_ptr = '0;
    logic [31:0]   cmd_len = '0;
    logic          done_valid, done_ready = 1'b1, done_err;
    logic          awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 ap_clk = ~ap_clk;

    vadd_ctrl_seq #(.ADDR_WIDTH(AW), .POLL_GAP(PG)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_ptr(cmd_a_ptr), .cmd_b_ptr(cmd_b_ptr), .cmd_c_ptr(cmd_c_ptr), .cmd_len(cmd_len),
        .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
        .m_axi_control_AWVALID(awvalid), .m_axi_control_AWREADY(awready), .m_axi_control_AWADDR(awaddr),
        .m_axi_control_WVALID(wvalid), .m_axi_control_WREADY(wready), .m_axi_control_WDATA(wdata),
        .m_axi_control_WSTRB(wstrb),
        .m_axi_control_BVALID(bvalid), .m_axi_control_BREADY(bready), .m_axi_control_BRESP(bresp),
        .m_axi_control_ARVALID(arvalid), .m_axi_control_ARREADY(arready), .m_axi_control_ARADDR(araddr),
        .m_axi_control_RVALID(rvalid), .m_axi_control_RREADY(rready), .m_axi_control_RDATA(rdata),
        .m_axi_control_RRESP(rresp)
    );

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int aw_delay = 0, w_delay = 0, err_idx = -1, zero_polls = 0;
    int aw_cnt = 0, w_cnt = 0, wr_count = 0, poll_cnt = 0;
    bit aw_got = 0, w_got = 0;

    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge ap_clk);
            s_aw = awvalid && awready; s_w = wvalid && wready; s_b = bvalid && bready;
            s_ar = arvalid && arready; s_r = rvalid && rready;
            @(posedge ap_clk); #2;
            if (!ap_rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
                continue;
            end
            if (s_b) begin bvalid = 0; wr_count++; end
            if (s_aw) aw_got = 1;
            if (s_w) w_got = 1;
            if (aw_got && w_got && !bvalid) begin
                bvalid = 1;
                bresp  = (wr_count == err_idx) ? 2'b10 : 2'b00;
                aw_got = 0; w_got = 0;
            end
            if (s_r) rvalid = 0;
            if (s_ar) begin
                rvalid = 1;
                rdata  = (poll_cnt >= zero_polls) ? 32'h0000_0002 : 32'hFFFF_FFFD;
                rresp  = 2'b00;
                poll_cnt++;
            end
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            awready = awvalid && (aw_cnt > aw_delay);
            w_cnt   = wvalid ? w_cnt + 1 : 0;
            wready  = wvalid && (w_cnt > w_delay);
            arready = arvalid;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [AW+31:0] exp_wr[$];
    logic           exp_done[$];
    logic [AW-1:0]  aw_q[$];
    logic [31:0]    w_q[$];
    int n_aw = 0, n_b = 0, n_ar = 0, skew_cnt = 0, gap_checks = 0, done_cnt = 0;
    int cmd_cyc = 0, first_ar_cyc = -1, idle_cnt = 0;
    bit idle_on = 0;

    initial begin
        logic          pv_aw = 0, pv_awr = 0, pv_w = 0, pv_wr = 0;
        logic [AW-1:0] pv_awaddr = '0;
        logic [31:0]   pv_wdata = '0;
        logic [AW-1:0] a;
        logic [31:0]   d;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                pv_aw = 0; pv_w = 0; idle_on = 0;
                aw_q.delete(); w_q.delete();
                continue;
            end
            if (pv_aw && !pv_awr) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, pv_awaddr}));
            if (pv_w && !pv_wr)   chk("w_hold", 64'({wvalid, wdata}), 64'({1'b1, pv_wdata}));
            if (cmd_valid && cmd_ready) cmd_cyc = cyc;
            if (arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
            if (awvalid && !wvalid) skew_cnt++;
            if (awvalid && awready) begin aw_q.push_back(awaddr); n_aw++; end
            if (wvalid && wready) w_q.push_back(wdata);
            if (aw_q.size() > 0 && w_q.size() > 0) begin
                a = aw_q.pop_front();
                d = w_q.pop_front();
                $display("[TB] write addr=0x%02h data=0x%08h strb=%h", a, d, wstrb);
                if (exp_wr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", a, d);
                end else begin
                    chk("write", 64'({a, d}), 64'(exp_wr.pop_front()));
                end
            end
            if (bvalid && bready) n_b++;
            if (idle_on) begin
                if (arvalid) begin
                    chk("poll_gap", 64'(idle_cnt), 64'(PG));
                    gap_checks++;
                    idle_on = 0;
                end else if (!rready) idle_cnt++;
            end
            if (arvalid && arready) begin
                n_ar++;
                $display("[TB] poll AR at cycle %0d", cyc);
                chk("araddr", 64'(araddr), 64'(0));
            end
            if (rvalid && rready) begin
                idle_on  = (rdata[1] == 1'b0) && (rresp == 2'b00);
                idle_cnt = 0;
            end
            if (done_valid && done_ready) begin
                $display("[TB] done err=%0d", done_err);
                done_cnt++;
                idle_on = 0;
                if (exp_done.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got err %0d, expected no completion", done_err);
                end else begin
                    chk("done_err", 64'(done_err), 64'(exp_done.pop_front()));
                end
            end
            pv_aw = awvalid; pv_awr = awready; pv_awaddr = awaddr;
            pv_w  = wvalid;  pv_wr  = wready;  pv_wdata  = wdata;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] addr_tbl[8] = '{8'h10, 8'h14, 8'h1C, 8'h20, 8'h28, 8'h2C, 8'h34, 8'h00};

    task automatic start_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [31:0] len, input logic [31:0] ed[8], input int n_exp,
                             input logic exp_err, input int e_idx, input int zp,
                             input int awd, input int wd);
        int k;
        aw_delay = awd; w_delay = wd; err_idx = e_idx; zero_polls = zp;
        wr_count = 0; poll_cnt = 0;
        n_aw = 0; n_b = 0; n_ar = 0; skew_cnt = 0; gap_checks = 0; first_ar_cyc = -1;
        for (int i = 0; i < n_exp; i++) exp_wr.push_back({AW'(addr_tbl[i]), ed[i]});
        exp_done.push_back(exp_err);
        @(posedge ap_clk); #2;
        cmd_valid = 1; cmd_a_ptr = a; cmd_b_ptr = b; cmd_c_ptr = c; cmd_len = len;
        k = 0;
        do begin @(negedge ap_clk); k++; end while (!cmd_ready && k < 20);
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL cmd_timeout: got cmd_ready 0, expected 1");
        end
        @(posedge ap_clk); #2;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int start = done_cnt;
        int k = 0;
        while (done_cnt == start && k < limit) begin @(posedge ap_clk); k++; end
        @(negedge ap_clk);
        if (done_cnt == start) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, expected one", name, limit);
        end
        chk({name, "_scoreboard_empty"}, 64'(exp_wr.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] ev[8];
        int k;
        // reset values
        repeat (2) @(negedge ap_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_wvalid", 64'(wvalid), 64'(0));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_bready", 64'(bready), 64'(0));
        chk("rst_rready", 64'(rready), 64'(0));
        chk("rst_done_valid", 64'(done_valid), 64'(0));
        chk("rst_done_err", 64'(done_err), 64'(0));
        chk("rst_awaddr", 64'(awaddr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("wstrb", 64'(wstrb), 64'hF);
        ap_rst_n = 1;

        // zero-wait job, ap_done on first poll
        ev = '{32'h0, 32'h1, 32'h2000, 32'h0, 32'h3000, 32'h0, 32'h10, 32'h1};
        start_job(64'h1_0000_0000, 64'h2000, 64'h3000, 32'd16, ev, 8, 1'b0, -1, 0, 0, 0);
        wait_done("zero_wait", 200);
        chk("zero_wait_first_ar_latency", 64'(first_ar_cyc - cmd_cyc), 64'(17));
        chk("zero_wait_ar_count", 64'(n_ar), 64'(1));
        chk("zero_wait_b_count", 64'(n_b), 64'(8));

        // WREADY three cycles ahead of AWREADY
        ev = '{32'h0000_1111, 32'hDEAD_BEEF, 32'h89AB_CDEF, 32'h0123_4567,
               32'h0000_0080, 32'h0000_0040, 32'h7, 32'h1};
        start_job(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 64'h0000_0040_0000_0080,
                  32'd7, ev, 8, 1'b0, -1, 0, 3, 0);
        wait_done("skew", 400);
        chk("skew_aw_only_cycles", 64'(skew_cnt), 64'(24));
        chk("skew_aw_count", 64'(n_aw), 64'(8));
        chk("skew_b_count", 64'(n_b), 64'(8));

        // three not-done polls then done
        ev = '{32'h100, 32'h0, 32'h200, 32'h0, 32'h300, 32'h0, 32'h40, 32'h1};
        start_job(64'h100, 64'h200, 64'h300, 32'd64, ev, 8, 1'b0, -1, 3, 0, 0);
        wait_done("poll", 400);
        chk("poll_ar_count", 64'(n_ar), 64'(4));
        chk("poll_gap_checks", 64'(gap_checks), 64'(3));

        // BRESP error on third write
        ev = '{32'hA0, 32'h0, 32'hB0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        start_job(64'hA0, 64'hB0, 64'hC0, 32'd5, ev, 3, 1'b1, 2, 0, 0, 0);
        wait_done("wr_err", 200);
        repeat (5) @(negedge ap_clk);
        chk("wr_err_aw_count", 64'(n_aw), 64'(3));
        chk("wr_err_ar_count", 64'(n_ar), 64'(0));

        // zero-length job runs normally
        ev = '{32'h40, 32'h0, 32'h80, 32'h0, 32'hC0, 32'h0, 32'h0, 32'h1};
        start_job(64'h40, 64'h80, 64'hC0, 32'd0, ev, 8, 1'b0, -1, 0, 0, 0);
        wait_done("len0", 200);

        // reset while polling
        ev = '{32'h5, 32'h0, 32'h6, 32'h0, 32'h7, 32'h0, 32'h8, 32'h1};
        start_job(64'h5, 64'h6, 64'h7, 32'd8, ev, 8, 1'b0, -1, 1000, 0, 0);
        k = 0;
        do begin @(negedge ap_clk); k++; end while (!(arvalid && n_ar >= 1) && k < 200);
        chk("rst_mid_arvalid_before", 64'(arvalid), 64'(1));
        #1 ap_rst_n = 0;
        #1;
        chk("rst_mid_arvalid_async", 64'(arvalid), 64'(0));
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        exp_done.delete();
        exp_wr.delete();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1;
        @(negedge ap_clk);
        chk("rst_mid_cmd_ready_after", 64'(cmd_ready), 64'(1));
        chk("rst_mid_rready_after", 64'(rready), 64'(0));
        ev = '{32'h0, 32'h1, 32'h2000, 32'h0, 32'h3000, 32'h0, 32'h10, 32'h1};
        start_job(64'h1_0000_0000, 64'h2000, 64'h3000, 32'd16, ev, 8, 1'b0, -1, 0, 0, 0);
        wait_done("post_rst", 200);
        chk("post_rst_first_ar_latency", 64'(first_ar_cyc - cmd_cyc), 64'(17));

        // completion backpressure (error job so done_err=1 must hold)
        done_ready = 0;
        ev = '{32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        start_job(64'h1234, 64'h0, 64'h0, 32'd1, ev, 1, 1'b1, 0, 0, 0, 0);
        k = 0;
        do begin @(negedge ap_clk); k++; end while (!done_valid && k < 100);
        @(posedge ap_clk); #2;
        cmd_valid = 1; cmd_a_ptr = 64'hBAD; cmd_len = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("bp_done_valid", 64'(done_valid), 64'(1));
            chk("bp_done_err", 64'(done_err), 64'(1));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        @(posedge ap_clk); #2;
        cmd_valid = 0;
        done_ready = 1;
        @(negedge ap_clk);
        chk("bp_done_handshake", 64'(done_valid), 64'(1));
        @(negedge ap_clk);
        chk("bp_idle_next_cycle", 64'(cmd_ready), 64'(1));
        chk("bp_done_dropped", 64'(done_valid), 64'(0));
        chk("bp_exp_done_empty", 64'(exp_done.size()), 64'(0));
        repeat (3) @(negedge ap_clk);
        chk("bp_no_stray_write", 64'(awvalid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected earlier finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vadd_ctrl_seq.md
VADD_CTRL_SEQ -- requirements
Module: vadd_ctrl_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning the control-register AXI4-Lite address width.
REQ-002 SHALL have parameter POLL_GAP, default 4, meaning the idle cycles between consecutive ap_done status polls (minimum 1).
REQ-003 SHALL have one clock and an asynchronous active-low reset, as the following ports:
- ap_clk  in  1  sole clock; all state changes on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  job request valid
- cmd_ready  out  1  block accepts a job
- cmd_a_ptr  in  64  source A base address
- cmd_b_ptr  in  64  source B base address
- cmd_c_ptr  in  64  result C base address
- cmd_len  in  32  element count
- done_valid  out  1  job finished
- done_ready  in  1  completion acknowledged
- done_err  out  1  a nonzero BRESP or RRESP occurred during the job
- m_axi_control_AWVALID / AWREADY  out / in  1  write-address handshake
- m_axi_control_AWADDR  out  ADDR_WIDTH  write address
- m_axi_control_WVALID / WREADY  out / in  1  write-data handshake
- m_axi_control_WDATA  out  32  write data
- m_axi_control_WSTRB  out  4  byte strobes, constant 4'hF
- m_axi_control_BVALID / BREADY  in / out  1  write-response handshake
- m_axi_control_BRESP  in  2  write response
- m_axi_control_ARVALID / ARREADY  out / in  1  read-address handshake
- m_axi_control_ARADDR  out  ADDR_WIDTH  read address, constant 0x00
- m_axi_control_RVALID / RREADY  in / out  1  read-data handshake
- m_axi_control_RDATA  in  32  read data; bit1 = ap_done
- m_axi_control_RRESP  in  2  read response

Function
REQ-004 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, GAP and DONE.
REQ-005 SHALL drive cmd_ready=1 only in IDLE, capture all cmd_* fields on the cmd_valid&cmd_ready cycle, clear the error flag, and enter WR_REQ on the next cycle.
REQ-006 SHALL issue exactly 8 writes in this order: 0x10 a[31:0], 0x14 a[63:32], 0x1C b[31:0], 0x20 b[63:32], 0x28 c[31:0], 0x2C c[63:32], 0x34 len, 0x00 data 0x1 (ap_start).
REQ-007 SHALL, in WR_REQ, assert AWVALID and WVALID in the same cycle and drop each independently after its own handshake; address and data SHALL remain stable while valid; the state SHALL move to WR_RESP once both handshakes complete, including the case where they complete on different cycles.
REQ-008 SHALL hold BREADY=1 only in WR_RESP and SHALL NOT start the next write before the B handshake.
REQ-009 SHALL, on a BRESP!=0, set the error flag, abort the remaining writes and enter DONE.
REQ-010 SHALL, after the ap_start B handshake, enter RD_REQ, assert ARVALID until ARREADY, then hold RREADY=1 in RD_RESP.
REQ-011 SHALL, on the R handshake: enter DONE with error set if RRESP!=0; enter DONE if RDATA[1]=1; otherwise enter GAP, count POLL_GAP cycles, then return to RD_REQ.
REQ-012 SHALL assert done_valid and done_err only in DONE, hold them stable until done_ready, then return to IDLE on the next cycle.
REQ-013 SHALL start the kernel normally when cmd_len=0, with no special casing.
REQ-014 SHALL ignore cmd_valid outside IDLE.
REQ-015 SHALL, with a zero-wait slave (all readies 1, B/R one cycle after request), use 2 cycles per write, giving the first ARVALID 17 cycles after the cmd handshake.

Reset
REQ-016 SHALL, while ap_rst_n=0, immediately force: FSM to IDLE; cmd_ready=1 once out of reset; all AXI valids/readies, done_valid, done_err and the gap counter to 0; AWADDR and WDATA to 0. This applies at any point in operation, including mid-transaction.

Verification
REQ-017 SHALL pass a zero-wait job: a=0x1_0000_0000, b=0x2000, c=0x3000, len=16, with ap_done set on the first poll. Required response: write sequence of REQ-006 with data 0x0,0x1,0x2000,0x0,0x3000,0x0,0x10,0x1; done_valid=1, done_err=0.
REQ-018 SHALL pass a skewed handshake: WREADY asserted 3 cycles before AWREADY. Required response: WVALID drops after its handshake while AWVALID holds; exactly one B is awaited; no duplicate write occurs.
REQ-019 SHALL pass polling: ap_done returns 0 for three polls, then 1, with POLL_GAP=4. Required response: 4 AR handshakes, spaced by 4 idle cycles each, then DONE.
REQ-020 SHALL pass a write error: BRESP=2'b10 on the third write. Required response: no further AW is issued; done_valid=1 with done_err=1.
REQ-021 SHALL pass reset mid-poll: ap_rst_n pulled low while ARVALID=1. Required response: ARVALID=0 asynchronously; after release cmd_ready=1, and a new job runs cleanly.
REQ-022 SHALL pass completion backpressure: done_ready held 0 for 5 cycles. Required response: done_valid/done_err stay stable and cmd_ready stays 0; IDLE is reached one cycle after done_ready=1.
